fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and instruction/operand register stage that sits directly upstream of the controller.
- Driven by the controller's fetch, PC_en, PC_chg_en and ADDR_sel strobes.
- Generates the shared ROM/RAM address, captures the opcode byte and the long-instruction operand byte from ROM, and presents the 4-bit opcode back to the controller as ins.
- Also maintains a halted flag and a retired-instruction counter for debug.

Parameters:
- AW, 8, address width of PC, operand register and memory address bus.
- DW, 8, ROM data width; instruction byte = {opcode[3:0], reg_sel[DW-5:0]}.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, active-high, asynchronous.
- fetch  in  2  from controller: 01 latch opcode byte, 10 latch operand byte, 00/11 hold.
- PC_en  in  1  from controller: PC update enable.
- PC_chg_en  in  1  from controller: with PC_en, load jump target instead of increment.
- ADDR_sel  in  1  from controller: 0 address = PC, 1 address = operand register.
- rom_dout  in  DW  ROM read data (combinational w.r.t. addr).
- addr  out  AW  shared ROM/RAM address.
- ins  out  4  current opcode to controller (ir[7:4]).
- reg_sel  out  DW-4  register-file index field (ir[3:0]).
- operand  out  AW  latched operand/address byte.
- pc  out  AW  current program counter.
- halted  out  1  set when HLT (4'b1111) has been latched as opcode.
- retired  out  CNT_W  count of opcodes latched.

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - pc = RESET_PC; ir = 8'h00, so ins = NOP; operand = 0; halted = 0; retired = 0.
  - addr therefore = RESET_PC.
- addr is combinational: ADDR_sel ? operand : pc. No registered latency.
- Opcode latch:
  - When fetch == 01 and !halted, ir <= rom_dout at the clock edge.
  - ins and reg_sel update the cycle after.
  - retired <= retired + 1 on the same edge; wraps modulo 2^CNT_W.
- Operand latch:
  - When fetch == 10, operand <= rom_dout[AW-1:0].
  - fetch == 11 is reserved and behaves as 00 (hold); it must not change ir or operand.
- PC update, evaluated in priority order each edge:
  1. halted: hold.
  2. PC_en & PC_chg_en: pc <= rom_dout[AW-1:0]. The jump target is the byte on the bus this cycle, not the previously latched operand. If fetch == 10 in the same cycle, operand also captures it.
  3. PC_en alone: pc <= pc + 1, wrapping 2^AW-1 to 0 with no flag.
  4. Otherwise hold.
  - PC_chg_en without PC_en is ignored.
- Halt:
  - halted <= 1 on the edge where fetch == 01 latches rom_dout[7:4] == 4'b1111.
  - Once set, halted stays set until reset: ir, pc and retired freeze; operand still follows fetch == 10 (harmless).
- Reset mid-operation: all state returns to reset values immediately, asynchronously, regardless of fetch/PC_en.
- Simultaneous fetch == 01 and PC_en: ir captures the byte at the old pc; pc increments on the same edge.

Decomposition:
- Shared package: opcode localparams (NOP..HLT, 4'b0000..4'b1111) and fetch encodings (F_HOLD = 00, F_OPC = 01, F_OPR = 10).
- The controller and this block use the same package.
- One natural sub-module: pc_reg (PC register with increment/load/hold priority and wrap), instantiated once. The IR, operand, halt and counter logic stays in the top level.

Test Plan:
- Reset, then ROM[0] = 8'h35, fetch = 01 for one cycle, then PC_en = 1 -> ins = 4'h3, reg_sel = 4'h5, pc = 1, retired = 1, addr = 1.
- Long load: ROM[1] = 8'h1A, ROM[2] = 8'h80, controller sequence fetch01 / PC_en / fetch10 / ADDR_sel = 1 -> operand = 8'h80 and addr = 8'h80 while ADDR_sel = 1; pc = 2 before the final PC_en, 3 after.
- JMP: rom_dout = 8'h40 with fetch = 10, PC_en = 1, PC_chg_en = 1 -> pc = 8'h40, operand = 8'h40 next cycle; same cycle with PC_chg_en = 1, PC_en = 0 -> pc unchanged.
- Wrap: pc = 8'hFF, PC_en = 1 -> pc = 8'h00.
- Halt: opcode byte 8'hF0 latched -> halted = 1 next cycle; subsequent fetch = 01 with 8'h60 and PC_en pulses leave ins = 4'hF, pc and retired frozen.
- Async reset pulse mid-cycle, between edges during a jump sequence -> pc = 0, ins = 0, halted = 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared opcode and fetch-strobe definitions used by fetch_unit and the controller.
package fetch_unit_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_LD  = 4'hB;
    localparam logic [3:0] OP_ST  = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_JZ  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        F_HOLD = 2'b00,
        F_OPC  = 2'b01,
        F_OPR  = 2'b10,
        F_RSVD = 2'b11
    } fetch_e;

    function automatic logic is_halt(input logic [3:0] op);
        return op == OP_HLT;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: freeze when halted, else load jump target, else increment, else hold.
module fetch_unit_pc_reg #(
    parameter int             AW       = 8,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          pc_en,
    input  logic          pc_chg_en,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (!hold && pc_en) begin
            // Increment wraps naturally at 2^AW; no carry is reported.
            pc_d = pc_chg_en ? target : pc_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// PC, instruction and operand register stage feeding the controller; also tracks halt
// and a count of latched opcodes for debug.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int             AW       = 8,
    parameter int             DW       = 8,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter int             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       fetch,
    input  logic             PC_en,
    input  logic             PC_chg_en,
    input  logic             ADDR_sel,
    input  logic [DW-1:0]    rom_dout,
    output logic [AW-1:0]    addr,
    output logic [3:0]       ins,
    output logic [DW-5:0]    reg_sel,
    output logic [AW-1:0]    operand,
    output logic [AW-1:0]    pc,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    fetch_e fetch_op;

    logic [DW-1:0]    ir_q,      ir_d;
    logic [AW-1:0]    operand_q, operand_d;
    logic             halted_q,  halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    assign fetch_op = fetch_e'(fetch);

    // The jump target comes straight off the ROM bus, not from the operand register.
    fetch_unit_pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .hold      (halted_q),
        .pc_en     (PC_en),
        .pc_chg_en (PC_chg_en),
        .target    (rom_dout[AW-1:0]),
        .pc        (pc)
    );

    always_comb begin
        ir_d      = ir_q;
        operand_d = operand_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        if (fetch_op == F_OPC && !halted_q) begin
            ir_d      = rom_dout;
            retired_d = retired_q + CNT_W'(1);
            if (is_halt(rom_dout[DW-1:DW-4])) halted_d = 1'b1;
        end
        // Operand capture is left running after halt; nothing downstream uses it then.
        if (fetch_op == F_OPR) operand_d = rom_dout[AW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q      <= '0;
            operand_q <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            ir_q      <= ir_d;
            operand_q <= operand_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign addr    = ADDR_sel ? operand_q : pc;
    assign ins     = ir_q[DW-1:DW-4];
    assign reg_sel = ir_q[DW-5:0];
    assign operand = operand_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences, then
// random traffic against a ROM image compared with a behavioural model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  fetch = 2'b00;
    logic        pc_en = 1'b0;
    logic        pc_chg_en = 1'b0;
    logic        addr_sel = 1'b0;
    logic [7:0]  rom_dout;
    logic [7:0]  addr;
    logic [3:0]  ins;
    logic [3:0]  reg_sel;
    logic [7:0]  operand;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] retired;

    logic        use_rom = 1'b0;
    logic [7:0]  bus_val = 8'h00;
    logic [7:0]  rom_mem [256];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, kept as plain integers.
    int m_pc, m_ir, m_opr, m_halt, m_ret;

    // Expected {pc, ir, operand, halted, retired, addr}.
    logic [48:0] exp_q[$];

    typedef struct {
        logic [1:0]  f;
        logic        pe;
        logic        ce;
        logic        as;
        logic [7:0]  bus;
        logic [7:0]  e_pc;
        logic [3:0]  e_ins;
        logic [3:0]  e_rs;
        logic [7:0]  e_opr;
        logic [15:0] e_ret;
        logic [7:0]  e_addr;
    } vec_t;

    vec_t tbl[11];

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fetch),
        .PC_en     (pc_en),
        .PC_chg_en (pc_chg_en),
        .ADDR_sel  (addr_sel),
        .rom_dout  (rom_dout),
        .addr      (addr),
        .ins       (ins),
        .reg_sel   (reg_sel),
        .operand   (operand),
        .pc        (pc),
        .halted    (halted),
        .retired   (retired)
    );

    // Clock and ROM model
    always #5 clk = ~clk;
    assign rom_dout = use_rom ? rom_mem[addr] : bus_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_opr = 0; m_halt = 0; m_ret = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fetch = 2'b00; pc_en = 1'b0; pc_chg_en = 1'b0; addr_sel = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic [1:0] f, input logic pe, input logic ce,
                         input logic as, input logic [7:0] bus);
        fetch = f; pc_en = pe; pc_chg_en = ce; addr_sel = as; bus_val = bus;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    // One clock of the model: the rules applied to the byte on the bus this cycle.
    task automatic model_step(input int f, input int pe, input int ce, input int bus);
        int was_halted;
        was_halted = m_halt;
        if (f == 1 && was_halted == 0) begin
            m_ir  = bus;
            m_ret = (m_ret + 1) % 65536;
            if (bus / 16 == 15) m_halt = 1;
        end
        if (f == 2) m_opr = bus;
        if (was_halted == 0 && pe == 1) begin
            if (ce == 1) m_pc = bus;
            else         m_pc = (m_pc + 1) % 256;
        end
    endtask

    task automatic random_cycle();
        int f, pe, ce, as, bus;
        logic [48:0] e;
        f  = $urandom_range(0, 3);
        pe = $urandom_range(0, 1);
        ce = $urandom_range(0, 3) == 0 ? 1 : 0;
        as = $urandom_range(0, 1);
        fetch = f[1:0]; pc_en = pe[0]; pc_chg_en = ce[0]; addr_sel = as[0];
        bus = int'(rom_mem[as == 1 ? m_opr : m_pc]);
        model_step(f, pe, ce, bus);
        e = {m_pc[7:0], m_ir[7:0], m_opr[7:0], m_halt[0], m_ret[15:0],
             (as == 1) ? m_opr[7:0] : m_pc[7:0]};
        exp_q.push_back(e);
        edge_settle();
        e = exp_q.pop_front();
        check("rnd_pc",      32'(pc),      32'(e[48:41]));
        check("rnd_ins",     32'(ins),     32'(e[40:37]));
        check("rnd_reg_sel", 32'(reg_sel), 32'(e[36:33]));
        check("rnd_operand", 32'(operand), 32'(e[32:25]));
        check("rnd_halted",  32'(halted),  32'(e[24]));
        check("rnd_retired", 32'(retired), 32'(e[23:8]));
        check("rnd_addr",    32'(addr),    32'(e[7:0]));
    endtask

    initial begin
        //            f      pe    ce    as    bus    pc     ins   rs    opr    ret    addr
        tbl[0]  = '{2'b01, 1'b0, 1'b0, 1'b0, 8'h35, 8'h00, 4'h3, 4'h5, 8'h00, 16'd1, 8'h00};
        tbl[1]  = '{2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 4'h3, 4'h5, 8'h00, 16'd1, 8'h01};
        tbl[2]  = '{2'b01, 1'b0, 1'b0, 1'b0, 8'h1A, 8'h01, 4'h1, 4'hA, 8'h00, 16'd2, 8'h01};
        tbl[3]  = '{2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 4'h1, 4'hA, 8'h00, 16'd2, 8'h02};
        tbl[4]  = '{2'b10, 1'b0, 1'b0, 1'b0, 8'h80, 8'h02, 4'h1, 4'hA, 8'h80, 16'd2, 8'h02};
        tbl[5]  = '{2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 4'h1, 4'hA, 8'h80, 16'd2, 8'h80};
        tbl[6]  = '{2'b00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h03, 4'h1, 4'hA, 8'h80, 16'd2, 8'h80};
        tbl[7]  = '{2'b10, 1'b1, 1'b1, 1'b0, 8'h40, 8'h40, 4'h1, 4'hA, 8'h40, 16'd2, 8'h40};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 1'b0, 8'h77, 8'h40, 4'h1, 4'hA, 8'h40, 16'd2, 8'h40};
        tbl[9]  = '{2'b11, 1'b0, 1'b0, 1'b0, 8'h99, 8'h40, 4'h1, 4'hA, 8'h40, 16'd2, 8'h40};
        tbl[10] = '{2'b01, 1'b1, 1'b0, 1'b0, 8'h25, 8'h41, 4'h2, 4'h5, 8'h40, 16'd3, 8'h41};

        // Reset state
        do_reset();
        #1;
        check("rst_pc",      32'(pc),      32'h00);
        check("rst_ins",     32'(ins),     32'h0);
        check("rst_operand", 32'(operand), 32'h00);
        check("rst_halted",  32'(halted),  32'h0);
        check("rst_retired", 32'(retired), 32'h0);
        check("rst_addr",    32'(addr),    32'h00);

        // Directed vector table
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].f, tbl[i].pe, tbl[i].ce, tbl[i].as, tbl[i].bus);
            edge_settle();
            check($sformatf("tbl%0d_pc", i),      32'(pc),      32'(tbl[i].e_pc));
            check($sformatf("tbl%0d_ins", i),     32'(ins),     32'(tbl[i].e_ins));
            check($sformatf("tbl%0d_reg_sel", i), 32'(reg_sel), 32'(tbl[i].e_rs));
            check($sformatf("tbl%0d_operand", i), 32'(operand), 32'(tbl[i].e_opr));
            check($sformatf("tbl%0d_retired", i), 32'(retired), 32'(tbl[i].e_ret));
            check($sformatf("tbl%0d_addr", i),    32'(addr),    32'(tbl[i].e_addr));
            check($sformatf("tbl%0d_halted", i),  32'(halted),  32'h0);
        end

        // PC wrap from 0xFF to 0x00
        drive(2'b00, 1'b1, 1'b1, 1'b0, 8'hFF);
        edge_settle();
        check("wrap_load_pc", 32'(pc), 32'hFF);
        drive(2'b00, 1'b1, 1'b0, 1'b0, 8'h00);
        edge_settle();
        check("wrap_pc", 32'(pc), 32'h00);

        // Halt: HLT latched, then everything but operand freezes
        drive(2'b01, 1'b0, 1'b0, 1'b0, 8'hF0);
        edge_settle();
        check("hlt_halted",  32'(halted),  32'h1);
        check("hlt_ins",     32'(ins),     32'hF);
        check("hlt_retired", 32'(retired), 32'd4);
        drive(2'b01, 1'b1, 1'b0, 1'b0, 8'h60);
        edge_settle();
        check("hlt_frz_ins",     32'(ins),     32'hF);
        check("hlt_frz_pc",      32'(pc),      32'h00);
        check("hlt_frz_retired", 32'(retired), 32'd4);
        drive(2'b10, 1'b1, 1'b1, 1'b0, 8'h12);
        edge_settle();
        check("hlt_jmp_pc",  32'(pc),      32'h00);
        check("hlt_operand", 32'(operand), 32'h12);
        check("hlt_still",   32'(halted),  32'h1);

        // Async reset between edges during a jump sequence
        do_reset();
        drive(2'b10, 1'b1, 1'b1, 1'b0, 8'h40);
        edge_settle();
        check("ar_jmp_pc", 32'(pc), 32'h40);
        drive(2'b01, 1'b0, 1'b0, 1'b0, 8'hF5);
        edge_settle();
        check("ar_pre_halted", 32'(halted), 32'h1);
        drive(2'b10, 1'b1, 1'b1, 1'b0, 8'h66);
        #2;
        rst = 1'b1;
        #1;
        check("ar_pc",      32'(pc),      32'h00);
        check("ar_ins",     32'(ins),     32'h0);
        check("ar_halted",  32'(halted),  32'h0);
        check("ar_retired", 32'(retired), 32'h0);
        check("ar_operand", 32'(operand), 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against a ROM image; HLT opcodes kept rare
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b[7:4] == 4'hF && $urandom_range(0, 7) != 0) b[7:4] = 4'($urandom_range(0, 14));
            rom_mem[i] = b;
        end
        use_rom = 1'b1;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            #1;
            for (int c = 0; c < 150; c++) random_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
